job_handshake_ctrl: RTL and testbench

//  Multi-channel start/done job controller, parametrised in channel count and watchdog timeout.

---
 rtl/fsm_ctrl_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/job_handshake_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_job_handshake_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fsm_ctrl_pkg
// Shared types and defaults for the job handshake controller.
//   state_t      : controller state, the encoding is also the debug code
//                  driven on the top-level 'out' port.
//   DEF_NUM_CH   : default number of requesting channels.
//   DEF_TIMEOUT  : default watchdog limit in BUSY cycles.
// -----------------------------------------------------------------------------
package fsm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10,
        ERR  = 2'b11
    } state_t;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_TIMEOUT = 1023;

endpackage : fsm_ctrl_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. The search starts at the channel
// after last_served and wraps around, so the channel served last has the
// lowest priority on the next pick.
// Ports:
//   req          in   NUM_CH  request vector
//   last_served  in   CH_W    index of the channel served most recently
//   gnt          out  NUM_CH  one-hot winner (all zero when no request)
//   gnt_id       out  CH_W    binary index of the winner (0 when no request)
//   any          out  1       at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last_served,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   gnt_id,
    output logic              any
);

    logic            found_s;
    logic [CH_W-1:0] idx_s;

    // Rotating first-set-bit search starting one past last_served.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        found_s = 1'b0;
        idx_s   = '0;
        any     = |req;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx_s = CH_W'((int'(last_served) + k) % NUM_CH);
            if (req[idx_s] && !found_s) begin
                found_s    = 1'b1;
                gnt[idx_s] = 1'b1;
                gnt_id     = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/job_handshake_ctrl.sv
// -----------------------------------------------------------------------------
// job_handshake_ctrl
// Multi-channel start/done job controller in front of a shared engine.
// A round-robin arbiter picks one requesting channel, the controller pulses
// go, waits for done, pulses complete on the served channel and returns to
// IDLE. With the watchdog built in, a job that stays in BUSY for TIMEOUT
// cycles parks the controller in ERR (ack=1) until init.
// Optional feature macro: FSM_TIMEOUT_EN (watchdog counter and ERR state).
// Ports:
//   clk       in   1       clock, rising edge
//   rst_n     in   1       asynchronous active-low reset
//   start     in   NUM_CH  per-channel level request
//   init      in   1       abort BUSY job / clear ERR
//   done      in   1       engine completion for the granted job
//   go        out  1       one-cycle pulse in the first BUSY cycle
//   grant     out  NUM_CH  one-hot engine owner, 0 when idle
//   grant_id  out  CH_W    binary index of grant
//   complete  out  NUM_CH  one-cycle pulse on the served channel (DONE)
//   ack       out  1       error flag, high only in ERR
//   out       out  2       current state code
// -----------------------------------------------------------------------------
module job_handshake_ctrl
    import fsm_ctrl_pkg::*;
#(
    parameter  int NUM_CH  = DEF_NUM_CH,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    localparam int CH_W    = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] start,
    input  logic              init,
    input  logic              done,
    output logic              go,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_id,
    output logic [NUM_CH-1:0] complete,
    output logic              ack,
    output logic [1:0]        out
);

    // Elaboration-time guard on the configuration.
    if ((NUM_CH < 2) || (TIMEOUT < 1)) begin : g_bad_cfg
        $error("job_handshake_ctrl: NUM_CH must be >= 2 and TIMEOUT >= 1");
    end

    state_t              state_r;
    state_t              state_nx_s;
    logic [NUM_CH-1:0]   grant_r;
    logic [CH_W-1:0]     grant_id_r;
    logic [CH_W-1:0]     last_r;
    logic [NUM_CH-1:0]   complete_r;
    logic                go_r;
    logic [NUM_CH-1:0]   arb_gnt_s;
    logic [CH_W-1:0]     arb_id_s;
    logic                arb_any_s;
    logic                tmo_s;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req         (start),
        .last_served (last_r),
        .gnt         (arb_gnt_s),
        .gnt_id      (arb_id_s),
        .any         (arb_any_s)
    );

`ifdef FSM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_r;
    logic             ack_r;

    // The count equals the number of completed BUSY cycles, so the cycle that
    // makes it reach TIMEOUT is the one where cnt_r is TIMEOUT-1.
    assign tmo_s = (cnt_r == CNT_W'(TIMEOUT - 1));

    // Watchdog: held at zero outside BUSY, counts BUSY cycles without done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (state_r != BUSY) begin
            cnt_r <= '0;
        end else if (!done && (cnt_r != CNT_W'(TIMEOUT))) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Error flag registered from the next state so it is high exactly in ERR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_r <= 1'b0;
        end else begin
            ack_r <= (state_nx_s == ERR);
        end
    end

    assign ack = ack_r;
`else
    assign tmo_s = 1'b0;
    assign ack   = 1'b0;
`endif

    // Next-state logic; done has priority over init and over the watchdog.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (arb_any_s) state_nx_s = BUSY;
                else           state_nx_s = IDLE;
            end
            BUSY: begin
                if (done)       state_nx_s = DONE;
                else if (init)  state_nx_s = IDLE;
                else if (tmo_s) state_nx_s = ERR;
                else            state_nx_s = BUSY;
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            ERR: begin
                if (init) state_nx_s = IDLE;
                else      state_nx_s = ERR;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State register, grant ownership, round-robin pointer and output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            grant_r    <= '0;
            grant_id_r <= '0;
            last_r     <= CH_W'(NUM_CH - 1);
            complete_r <= '0;
            go_r       <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            go_r       <= (state_r == IDLE) && arb_any_s;
            complete_r <= ((state_r == BUSY) && done) ? grant_r : '0;
            case (state_r)
                IDLE: begin
                    if (arb_any_s) begin
                        grant_r    <= arb_gnt_s;
                        grant_id_r <= arb_id_s;
                    end
                end
                BUSY: begin
                    // Abort keeps the pointer: the aborted channel keeps its turn.
                    if (!done && init) begin
                        grant_r    <= '0;
                        grant_id_r <= '0;
                    end
                end
                DONE: begin
                    last_r     <= grant_id_r;
                    grant_r    <= '0;
                    grant_id_r <= '0;
                end
                ERR: begin
                    // Stuck channel loses priority once the error is cleared.
                    if (init) begin
                        last_r     <= grant_id_r;
                        grant_r    <= '0;
                        grant_id_r <= '0;
                    end
                end
                default: begin
                    grant_r    <= '0;
                    grant_id_r <= '0;
                end
            endcase
        end
    end

    assign go       = go_r;
    assign grant    = grant_r;
    assign grant_id = grant_id_r;
    assign complete = complete_r;
    assign out      = state_r;

endmodule : job_handshake_ctrl

// File: tb/tb_job_handshake_ctrl.sv
module tb_job_handshake_ctrl;

    localparam int N = 4;
    localparam int T = 8;
`ifdef FSM_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] start = '0;
    logic         init = 1'b0;
    logic         done = 1'b0;
    logic         go;
    logic [N-1:0] grant;
    logic [1:0]   grant_id;
    logic [N-1:0] complete;
    logic         ack;
    logic [1:0]   out;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the engine, how long it has been busy,
    // which phase of the job we are in, and who was served last.
    int m_owner;
    int m_last;
    int m_busy;
    bit m_done_ph;
    bit m_err;
    bit m_go;

    always #5 clk = ~clk;

    job_handshake_ctrl #(.NUM_CH(N), .TIMEOUT(T)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .init     (init),
        .done     (done),
        .go       (go),
        .grant    (grant),
        .grant_id (grant_id),
        .complete (complete),
        .ack      (ack),
        .out      (out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_last    = N - 1;
        m_busy    = 0;
        m_done_ph = 1'b0;
        m_err     = 1'b0;
        m_go      = 1'b0;
    endtask

    function automatic int pick(input logic [N-1:0] s);
        for (int k = 1; k <= N; k++) begin
            if (s[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic [N-1:0] s, input logic i, input logic d);
        bit new_go;
        new_go = 1'b0;
        if (m_err) begin
            if (i) begin
                m_last  = m_owner;
                m_owner = -1;
                m_err   = 1'b0;
            end
        end else if (m_done_ph) begin
            m_last    = m_owner;
            m_owner   = -1;
            m_done_ph = 1'b0;
        end else if (m_owner >= 0) begin
            if (d)                      m_done_ph = 1'b1;
            else if (i)                 m_owner = -1;
            else if (TMO && m_busy == T) m_err = 1'b1;
            else                        m_busy++;
        end else if (s != '0) begin
            m_owner = pick(s);
            m_busy  = 1;
            new_go  = 1'b1;
        end
        m_go = new_go;
    endtask

    task automatic check_all();
        int eo;
        eo = m_err ? 3 : (m_done_ph ? 2 : (m_owner >= 0 ? 1 : 0));
        chk("out", 32'(out), 32'(eo));
        chk("ack", 32'(ack), 32'(m_err));
        chk("go", 32'(go), 32'(m_go));
        chk("grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("grant_id", 32'(grant_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk("complete", 32'(complete), m_done_ph ? (32'd1 << m_owner) : 32'd0);
    endtask

    // One clock: drive after the edge, advance the model at the edge, sample 1ns later.
    task automatic step(input logic [N-1:0] s, input logic i, input logic d);
        start = s;
        init  = i;
        done  = d;
        @(posedge clk);
        model_edge(s, i, d);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        start = '0;
        init  = 1'b0;
        done  = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step('0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // 1. async reset in the middle of a job, then a fresh grant
        step(4'b0001, 1'b0, 1'b0);
        chk("t1_go", 32'(go), 32'd1);
        step(4'b0001, 1'b0, 1'b0);
        do_reset();
        step(4'b0001, 1'b0, 1'b0);
        chk("t1_grant", 32'(grant), 32'd1);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);

        // 2. round robin with all channels requesting
        do_reset();
        for (int j = 0; j < 5; j++) begin
            step(4'b1111, 1'b0, 1'b0);
            chk("rr_order", 32'(grant_id), 32'(j % N));
            step(4'b1111, 1'b0, 1'b0);
            step(4'b1111, 1'b0, 1'b1);
            chk("rr_complete", 32'(complete), 32'd1 << (j % N));
            step(4'b1111, 1'b0, 1'b0);
        end

        // 3. single-job latency on channel 2
        do_reset();
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b1);
        chk("t3_complete", 32'(complete), 32'd4);
        step(4'b0000, 1'b0, 1'b0);
        chk("t3_idle", 32'(out), 32'd0);

        // 5a. done and init together -> done wins
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b1);
        chk("race_done_init", 32'(out), 32'd2);
        step(4'b0000, 1'b0, 1'b0);

        // 6a. abort in BUSY -> IDLE without complete
        step(4'b1000, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        chk("abort_idle", 32'(out), 32'd0);
        chk("abort_nocomp", 32'(complete), 32'd0);

`ifdef FSM_TIMEOUT_EN
        // 4. watchdog on channel 1, then clear and check priority moved on
        do_reset();
        step(4'b0010, 1'b0, 1'b0);
        for (int j = 0; j < T; j++) step(4'b0000, 1'b0, 1'b0);
        chk("tmo_err", 32'(out), 32'd3);
        chk("tmo_ack", 32'(ack), 32'd1);
        step(4'b0000, 1'b0, 1'b1);
        chk("tmo_done_ign", 32'(out), 32'd3);
        step(4'b0000, 1'b1, 1'b0);
        chk("tmo_clear", 32'(out), 32'd0);
        step(4'b1111, 1'b0, 1'b0);
        chk("tmo_next", 32'(grant), 32'd4);
        // 5b. done on the last allowed BUSY cycle
        for (int j = 0; j < T - 1; j++) step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b1);
        chk("tmo_race", 32'(out), 32'd2);
        step(4'b0000, 1'b0, 1'b0);
`else
        // 6b. without the watchdog BUSY waits indefinitely
        step(4'b0001, 1'b0, 1'b0);
        for (int j = 0; j < 5000; j++) step(4'b0000, 1'b0, 1'b0);
        chk("nowd_busy", 32'(out), 32'd1);
        chk("nowd_ack", 32'(ack), 32'd0);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0);
`endif

        // random traffic against the model
        for (int j = 0; j < 600; j++) begin
            step(4'($urandom_range(0, 15)),
                 ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 6) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_job_handshake_ctrl
